// File: rtl/hash_core.sv
// hash_core: iterative 128-bit ARX compression engine with Davies-Meyer
// feed-forward. It absorbs a stream of 64-bit message blocks into a 128-bit
// chaining value that is seeded from an external IV table.
//
// Optional feature macro: HASH_CORE_LEN_PAD_EN
//   defined   -> after the last block, one extra compression runs with the
//                block count as the message word (length padding).
//   undefined -> the digest is the chaining value right after the last block.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start, t                     begin a new hash with IV variant t (IDLE only)
//   iv_sel, iv                   select to the IV table and its combinational IV
//   msg_valid/ready/data/last    message-block stream, 64-bit blocks
//   busy                         high in every state except IDLE
//   digest_valid/ready, digest   result stream, digest held until accepted
module hash_core #(
    parameter int ROUNDS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   t,
    output logic [1:0]   iv_sel,
    input  logic [127:0] iv,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [63:0]  msg_data,
    input  logic         msg_last,
    output logic         busy,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [127:0] digest
);

`ifdef HASH_CORE_LEN_PAD_EN
    typedef enum logic [2:0] {IDLE, ABSORB, ROUND, FINAL, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ABSORB, ROUND, DONE} state_t;
`endif

    localparam logic [7:0] LAST_R = 8'(ROUNDS - 1);

    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    state_t         state, state_nx;
    logic [127:0]   h;          // chaining value {A, B}
    logic [127:0]   v;          // working copy {a, b}
    logic [63:0]    m;          // latched message block
    logic [63:0]    cnt;        // blocks absorbed so far
    logic [7:0]     r;          // round index within the current compression
    logic [1:0]     t_q;        // IV variant latched on start
    logic           last_q;     // latched msg_last of the block in flight

    logic           in_round;
    logic           last_round;
    logic [63:0]    m_cur;
    logic [63:0]    sum;
    logic [63:0]    a_n, b_n;
    logic [127:0]   h_ff;

    // Round datapath: one ARX round per clock on the working copy.
    always_comb begin
        in_round = (state == ROUND);
        m_cur    = m;
`ifdef HASH_CORE_LEN_PAD_EN
        // The length block reuses the round function with the block count as M.
        if (state == FINAL) begin
            in_round = 1'b1;
            m_cur    = cnt;
        end
`endif
        sum        = v[127:64] + v[63:0];
        a_n        = rotl(sum, 13) ^ m_cur;
        b_n        = rotl(v[63:0], 17) ^ a_n ^ {56'h0, r};
        h_ff       = h ^ {a_n, b_n};
        last_round = in_round && (r == LAST_R);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start) state_nx = ABSORB;
            ABSORB: if (msg_valid) state_nx = ROUND;
            ROUND: begin
                if (r == LAST_R) begin
                    if (!last_q)
                        state_nx = ABSORB;
                    else
`ifdef HASH_CORE_LEN_PAD_EN
                        state_nx = FINAL;
`else
                        state_nx = DONE;
`endif
                end
            end
`ifdef HASH_CORE_LEN_PAD_EN
            FINAL:  if (r == LAST_R) state_nx = DONE;
`endif
            DONE:   if (digest_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h      <= '0;
            v      <= '0;
            m      <= '0;
            cnt    <= '0;
            r      <= '0;
            t_q    <= '0;
            last_q <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                t_q <= t;
                h   <= iv;
                v   <= iv;
                cnt <= '0;
            end
        end else if (state == ABSORB) begin
            if (msg_valid) begin
                m      <= msg_data;
                last_q <= msg_last;
                cnt    <= cnt + 64'd1;
                v      <= h;
                r      <= '0;
            end
        end else if (in_round) begin
            v <= {a_n, b_n};
            r <= r + 8'd1;
            if (last_round) begin
                h <= h_ff;
                r <= '0;
`ifdef HASH_CORE_LEN_PAD_EN
                // Seed the length compression from the post-feed-forward value.
                if (state == ROUND && last_q) v <= h_ff;
`endif
            end
        end
    end

    assign iv_sel       = (state == IDLE) ? t : t_q;
    assign msg_ready    = (state == ABSORB);
    assign busy         = (state != IDLE);
    assign digest_valid = (state == DONE);
    assign digest       = h;

endmodule

// File: tb/tb_hash_core.sv
module tb_hash_core;
    localparam int ROUNDS = 8;
`ifdef HASH_CORE_LEN_PAD_EN
    localparam int LAT = 2 * ROUNDS;
`else
    localparam int LAT = ROUNDS;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   t;
    logic [1:0]   iv_sel;
    logic [127:0] iv;
    logic         msg_valid;
    logic         msg_ready;
    logic [63:0]  msg_data;
    logic         msg_last;
    logic         busy;
    logic         digest_valid;
    logic         digest_ready;
    logic [127:0] digest;

    int errors = 0;
    int checks = 0;
    logic [127:0] exp_q[$];
    logic [1:0]   cur_t;

    hash_core #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .t(t), .iv_sel(iv_sel), .iv(iv),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .msg_last(msg_last), .busy(busy), .digest_valid(digest_valid),
        .digest_ready(digest_ready), .digest(digest)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ivtab(input logic [1:0] s);
        case (s)
            2'd0:    return 128'h0123456789ABCDEF_FEDCBA9876543210;
            2'd1:    return 128'hDEADBEEFCAFEF00D_0000000000000001;
            2'd2:    return 128'h8000000000000000_7FFFFFFFFFFFFFFF;
            default: return 128'h0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
        endcase
    endfunction

    always_comb iv = ivtab(iv_sel);

    function automatic logic [63:0] rl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [127:0] compress(input logic [127:0] hv, input logic [63:0] mw);
        logic [63:0] a, b, s, na, nb;
        a = hv[127:64];
        b = hv[63:0];
        for (int k = 0; k < ROUNDS; k++) begin
            s  = a + b;
            na = rl(s, 13) ^ mw;
            nb = rl(b, 17) ^ na ^ 64'(k);
            a  = na;
            b  = nb;
        end
        return hv ^ {a, b};
    endfunction

    function automatic logic [127:0] model(input logic [1:0] tv, input logic [63:0] b0,
                                           input logic [63:0] b1, input logic [63:0] b2,
                                           input int n);
        logic [127:0] hv;
        logic [63:0]  blk[3];
        blk[0] = b0; blk[1] = b1; blk[2] = b2;
        hv = ivtab(tv);
        for (int k = 0; k < n; k++) hv = compress(hv, blk[k]);
`ifdef HASH_CORE_LEN_PAD_EN
        hv = compress(hv, 64'(n));
`endif
        return hv;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every cycle the digest is offered it must match the
    // head of the queue; the entry retires on the handshake.
    always @(negedge clk) begin
        if (rst_n && digest_valid) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_digest", digest, 128'h0);
            end else begin
                chk(digest === exp_q[0], "digest", digest, exp_q[0]);
                if (digest_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] tv);
        start = 1'b1;
        t     = tv;
        cur_t = tv;
        @(negedge clk);
        chk(busy === 1'b0, "idle_busy", 128'(busy), 128'd0);
        chk(iv_sel === tv, "iv_sel_idle", 128'(iv_sel), 128'(tv));
        step();
        start = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] data, input bit last, input int gap,
                              input bit poke);
        int n;
        bit seen;
        repeat (gap) step();
        msg_valid = 1'b1;
        msg_data  = data;
        msg_last  = last;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = msg_ready;
        end
        chk(seen, "accept_timeout", 128'(seen), 128'd1);
        step();
        msg_valid = 1'b0;
        msg_data  = '0;
        msg_last  = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            chk(iv_sel === cur_t, "iv_sel_latched", 128'(iv_sel), 128'(cur_t));
            if (poke && n == 2) begin
                start = 1'b1;
                t     = ~cur_t;
            end
            if (poke && n == 3) begin
                start = 1'b0;
                t     = cur_t;
            end
            seen = last ? digest_valid : msg_ready;
        end
        chk((n - 1) == (last ? LAT : ROUNDS), last ? "digest_latency" : "ready_gap",
            128'(n - 1), 128'(last ? LAT : ROUNDS));
        step();
    endtask

    task automatic run_hash(input logic [1:0] tv, input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input int n, input int gap);
        logic [63:0] blk[3];
        blk[0] = b0; blk[1] = b1; blk[2] = b2;
        exp_q.push_back(model(tv, b0, b1, b2, n));
        do_start(tv);
        for (int k = 0; k < n; k++) send_block(blk[k], k == n - 1, gap, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; t = 2'd2; cur_t = 2'd0;
        msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; digest_ready = 1'b1;
        #3;
        chk(busy === 1'b0, "rst_busy", 128'(busy), 128'd0);
        chk(msg_ready === 1'b0, "rst_msg_ready", 128'(msg_ready), 128'd0);
        chk(digest_valid === 1'b0, "rst_digest_valid", 128'(digest_valid), 128'd0);
        chk(digest === 128'd0, "rst_digest", digest, 128'd0);
        chk(iv_sel === 2'd2, "rst_iv_sel", 128'(iv_sel), 128'd2);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Three-block messages with gaps in msg_valid, one per IV variant.
        for (int k = 0; k < 4; k++)
            run_hash(2'(k), 64'h1111_2222_3333_4444 + 64'(k), 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h0000_0000_0000_0000 ^ 64'(k << 8), 3, k + 1);

        // Single-block message, last on the first block, zero message word.
        run_hash(2'd0, 64'h0, 64'h0, 64'h0, 1, 0);

        // Two-block message.
        run_hash(2'd3, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0000_0000_0000_0080, 64'h0, 2, 0);

        // Back-pressure on the digest plus ignored start pulses in ROUND and DONE.
        digest_ready = 1'b0;
        exp_q.push_back(model(2'd2, 64'hCAFE_0000_0000_BABE, 64'h0123_0000_4567_0000, 64'h0, 2));
        do_start(2'd2);
        send_block(64'hCAFE_0000_0000_BABE, 1'b0, 1, 1'b1);
        send_block(64'h0123_0000_4567_0000, 1'b1, 0, 1'b1);
        start = 1'b1;
        t     = 2'd1;
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge clk);
            chk(digest_valid === 1'b1, "hold_valid", 128'(digest_valid), 128'd1);
            chk(iv_sel === 2'd2, "hold_iv_sel", 128'(iv_sel), 128'd2);
        end
        step();
        start = 1'b0;
        digest_ready = 1'b1;
        step();
        @(negedge clk);
        chk(busy === 1'b0, "post_hs_busy", 128'(busy), 128'd0);
        chk(digest_valid === 1'b0, "post_hs_valid", 128'(digest_valid), 128'd0);
        step();

        // Asynchronous reset in the middle of a compression.
        do_start(2'd1);
        msg_valid = 1'b1;
        msg_data  = 64'h7777_8888_9999_AAAA;
        msg_last  = 1'b0;
        step();
        msg_valid = 1'b0;
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        t     = 2'd3;
        #1;
        chk(busy === 1'b0, "mid_rst_busy", 128'(busy), 128'd0);
        chk(msg_ready === 1'b0, "mid_rst_msg_ready", 128'(msg_ready), 128'd0);
        chk(digest_valid === 1'b0, "mid_rst_valid", 128'(digest_valid), 128'd0);
        chk(digest === 128'd0, "mid_rst_digest", digest, 128'd0);
        chk(iv_sel === 2'd3, "mid_rst_iv_sel", 128'(iv_sel), 128'd3);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_hash(2'd1, 64'h7777_8888_9999_AAAA, 64'h1, 64'h0, 2, 0);

        // Back-to-back hashes: start lands in the first IDLE cycle after a handshake.
        run_hash(2'd0, 64'h0000_0000_0000_0001, 64'h0, 64'h0, 1, 0);
        run_hash(2'd2, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h2, 3, 0);

        repeat (3) step();
        chk(exp_q.size() == 0, "scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
